// File: rtl/mips32_pkg.sv
//==============================================================================
// Module   : mips32_pkg
// Brief    : Shared MIPS_32 constants: instruction width, address width, opcodes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mips32_pkg;

  localparam int INSTR_W = 32;
  localparam int AW      = 10;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] ir);
    return ir[INSTR_W-1:INSTR_W-6];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips32_sync_fifo.sv
//==============================================================================
// Module   : mips32_sync_fifo
// Brief    : Small synchronous FIFO with flush; head reads as zero when empty.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mips32_sync_fifo
  import mips32_pkg::*;
#(
  parameter int WIDTH = INSTR_W + mips32_pkg::AW,
  parameter int DEPTH = 4
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int c_pw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_pw-1:0]  r_rd;
  logic [c_pw-1:0]  r_wr;
  logic [c_pw:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Flush overrides both push and pop in the same cycle.
  assign w_do_push = push & ~flush;
  assign w_do_pop  = pop & ~flush & (r_count != '0);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + c_pw'(1);
      if (w_do_pop)  r_rd <= r_rd + c_pw'(1);
      r_count <= r_count + (c_pw+1)'(w_do_push) - (c_pw+1)'(w_do_pop);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
        r_mem[gi] <= '0;
      end else if (w_do_push && (r_wr == c_pw'(gi))) begin
        r_mem[gi] <= push_data;
      end
    end
  end

  assign count = r_count;
  assign head  = (r_count != '0) ? r_mem[r_rd] : '0;

endmodule

`default_nettype wire

// File: rtl/mips32_ifetch_queue.sv
//==============================================================================
// Module   : mips32_ifetch_queue
// Brief    : Credit-limited instruction prefetcher with flush-on-redirect queue.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mips32_ifetch_queue
  import mips32_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter int            AW       = mips32_pkg::AW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                halted,
  input  logic                redirect_valid,
  input  logic [AW-1:0]       redirect_pc,
  output logic                imem_req,
  output logic [AW-1:0]       imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                id_valid,
  output logic [INSTR_W-1:0]  id_ir,
  output logic [INSTR_W-1:0]  id_npc,
  input  logic                id_ready
);

  localparam int                c_cnt_w = $clog2(DEPTH) + 1;
  localparam int                c_fw    = INSTR_W + AW;
  localparam logic [c_cnt_w:0]  c_depth = (c_cnt_w+1)'(DEPTH);

  logic [AW-1:0]      r_fetch_pc;
  logic [AW-1:0]      r_rsp_pc;
  logic [c_cnt_w-1:0] r_outst;
  logic [c_cnt_w-1:0] r_drop;

  logic [c_cnt_w-1:0] w_count;
  logic [c_fw-1:0]    w_head;
  logic [c_cnt_w:0]   w_inflight;
  logic               w_credit;
  logic               w_fire;
  logic               w_rsp;
  logic               w_dropping;
  logic               w_push;
  logic               w_pop;
  logic [AW-1:0]      w_npc;

  // Queued plus outstanding never exceeds DEPTH, so a push always finds room.
  assign w_inflight = {1'b0, w_count} + {1'b0, r_outst};
  assign w_credit   = w_inflight < c_depth;

  assign imem_req   = rst_n & ~halted & ~redirect_valid & w_credit;
  assign imem_addr  = r_fetch_pc;
  assign w_fire     = imem_req & imem_gnt;

  assign w_rsp      = imem_rvalid & (r_outst != '0);
  assign w_dropping = (r_drop != '0);
  assign w_push     = w_rsp & ~w_dropping & ~redirect_valid;
  assign w_pop      = id_valid & id_ready;
  assign w_npc      = r_rsp_pc + AW'(1);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      // Every response still in flight after this cycle belongs to the old stream.
      r_fetch_pc <= redirect_pc;
      r_rsp_pc   <= redirect_pc;
      r_outst    <= r_outst - c_cnt_w'(w_rsp);
      r_drop     <= r_outst - c_cnt_w'(w_rsp);
    end else begin
      r_outst <= r_outst + c_cnt_w'(w_fire) - c_cnt_w'(w_rsp);
      if (w_fire)              r_fetch_pc <= r_fetch_pc + AW'(1);
      if (w_rsp && w_dropping) r_drop     <= r_drop - c_cnt_w'(1);
      if (w_push)              r_rsp_pc   <= w_npc;
    end
  end

  mips32_sync_fifo #(
    .WIDTH (c_fw),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({imem_rdata, w_npc}),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .count     (w_count),
    .head      (w_head)
  );

  assign id_valid = (w_count != '0) & ~redirect_valid;
  assign id_ir    = w_head[c_fw-1:AW];
  assign id_npc   = {{(INSTR_W-AW){1'b0}}, w_head[AW-1:0]};

`ifndef SYNTHESIS
  a_no_orphan_rvalid: assert property (@(posedge clk1) disable iff (!rst_n)
    imem_rvalid |-> (r_outst != '0));
`endif

endmodule

`default_nettype wire
